// File: rtl/m68k_bus_master.sv
// 68000 bus initiator: runs one S0..S7 read/write per accepted command, paced by the
// 8 MHz enable pulses, with DTACK_N/BERR_N wait-state handling and an optional timeout.
module m68k_bus_master #(
    parameter int TIMEOUT = 64,
    parameter int TO_W    = 7
) (
    input  logic        clk32,
    input  logic        res,
    input  logic        MHZ8_EN1,
    input  logic        MHZ8_EN2,
    input  logic        req,
    input  logic        we,
    input  logic [22:0] addr,
    input  logic        uds,
    input  logic        lds,
    input  logic [2:0]  fc,
    input  logic [15:0] wdata,
    output logic        busy,
    output logic        ack,
    output logic        berr,
    output logic [15:0] rdata,
    output logic [22:0] A,
    output logic [2:0]  FC,
    output logic        AS_N,
    output logic        UDS_N,
    output logic        LDS_N,
    output logic        RW,
    output logic [15:0] DOUT,
    output logic        DOE,
    input  logic [15:0] DIN,
    input  logic        DTACK_N,
    input  logic        BERR_N
);

    typedef enum logic [3:0] {
        IDLE, S0, S1, S2, S3, S4, S5, S6, S7, W
    } state_t;

    localparam bit            TO_EN  = (TIMEOUT != 0);
    localparam logic [TO_W-1:0] TO_VAL = TO_W'(TIMEOUT);

    state_t          state, state_d;
    logic            we_l, we_l_d;
    logic [22:0]     addr_l, addr_l_d;
    logic            uds_l, uds_l_d;
    logic            lds_l, lds_l_d;
    logic [2:0]      fc_l, fc_l_d;
    logic [15:0]     wdata_l, wdata_l_d;
    logic            berr_f, berr_f_d;
    logic [TO_W-1:0] wait_cnt, wait_cnt_d;

    logic            busy_d, ack_d, berr_d;
    logic [15:0]     rdata_d;
    logic [22:0]     a_d;
    logic [2:0]      fc_d;
    logic            as_n_d, uds_n_d, lds_n_d, rw_d;
    logic [15:0]     dout_d;
    logic            doe_d;

    // Every register, bus outputs included, is updated here so the pins come straight off flops.
    always_ff @(posedge clk32) begin
        if (res) begin
            state    <= IDLE;
            we_l     <= 1'b0;
            addr_l   <= '0;
            uds_l    <= 1'b0;
            lds_l    <= 1'b0;
            fc_l     <= '0;
            wdata_l  <= '0;
            berr_f   <= 1'b0;
            wait_cnt <= '0;
            busy     <= 1'b0;
            ack      <= 1'b0;
            berr     <= 1'b0;
            rdata    <= '0;
            A        <= '0;
            FC       <= '0;
            AS_N     <= 1'b1;
            UDS_N    <= 1'b1;
            LDS_N    <= 1'b1;
            RW       <= 1'b1;
            DOUT     <= '0;
            DOE      <= 1'b0;
        end else begin
            state    <= state_d;
            we_l     <= we_l_d;
            addr_l   <= addr_l_d;
            uds_l    <= uds_l_d;
            lds_l    <= lds_l_d;
            fc_l     <= fc_l_d;
            wdata_l  <= wdata_l_d;
            berr_f   <= berr_f_d;
            wait_cnt <= wait_cnt_d;
            busy     <= busy_d;
            ack      <= ack_d;
            berr     <= berr_d;
            rdata    <= rdata_d;
            A        <= a_d;
            FC       <= fc_d;
            AS_N     <= as_n_d;
            UDS_N    <= uds_n_d;
            LDS_N    <= lds_n_d;
            RW       <= rw_d;
            DOUT     <= dout_d;
            DOE      <= doe_d;
        end
    end

    always_comb begin
        state_d    = state;
        we_l_d     = we_l;
        addr_l_d   = addr_l;
        uds_l_d    = uds_l;
        lds_l_d    = lds_l;
        fc_l_d     = fc_l;
        wdata_l_d  = wdata_l;
        berr_f_d   = berr_f;
        wait_cnt_d = wait_cnt;
        busy_d     = busy;
        ack_d      = 1'b0;
        berr_d     = berr;
        rdata_d    = rdata;
        a_d        = A;
        fc_d       = FC;
        as_n_d     = AS_N;
        uds_n_d    = UDS_N;
        lds_n_d    = LDS_N;
        rw_d       = RW;
        dout_d     = DOUT;
        doe_d      = DOE;

        case (state)
            IDLE: begin
                if (!busy) begin
                    if (req) begin
                        // No byte enable at all means a full word access.
                        we_l_d    = we;
                        addr_l_d  = addr;
                        uds_l_d   = uds | ~(uds | lds);
                        lds_l_d   = lds | ~(uds | lds);
                        fc_l_d    = fc;
                        wdata_l_d = wdata;
                        busy_d    = 1'b1;
                    end
                end else if (MHZ8_EN1) begin
                    state_d    = S0;
                    a_d        = addr_l;
                    fc_d       = fc_l;
                    rw_d       = 1'b1;
                    berr_f_d   = 1'b0;
                    wait_cnt_d = '0;
                end
            end
            S0: if (MHZ8_EN2) state_d = S1;
            S1: begin
                if (MHZ8_EN1) begin
                    state_d = S2;
                    as_n_d  = 1'b0;
                    if (we_l) begin
                        rw_d = 1'b0;
                    end else begin
                        uds_n_d = ~uds_l;
                        lds_n_d = ~lds_l;
                    end
                end
            end
            S2: begin
                if (MHZ8_EN2) begin
                    state_d = S3;
                    if (we_l) begin
                        dout_d = wdata_l;
                        doe_d  = 1'b1;
                    end
                end
            end
            S3: begin
                if (MHZ8_EN1) begin
                    state_d = S4;
                    if (we_l) begin
                        uds_n_d = ~uds_l;
                        lds_n_d = ~lds_l;
                    end
                end
            end
            S4: begin
                // Bus error takes priority over a simultaneous DTACK.
                if (MHZ8_EN2) begin
                    if (!BERR_N) begin
                        state_d  = S5;
                        berr_f_d = 1'b1;
                    end else if (!DTACK_N) begin
                        state_d = S5;
                    end else if (TO_EN && (wait_cnt == TO_VAL)) begin
                        state_d  = S5;
                        berr_f_d = 1'b1;
                    end else begin
                        state_d    = W;
                        wait_cnt_d = wait_cnt + 1'b1;
                    end
                end
            end
            W:  if (MHZ8_EN1) state_d = S4;
            S5: if (MHZ8_EN1) state_d = S6;
            S6: begin
                if (MHZ8_EN2) begin
                    state_d = S7;
                    as_n_d  = 1'b1;
                    uds_n_d = 1'b1;
                    lds_n_d = 1'b1;
                    if (!we_l && !berr_f) rdata_d = DIN;
                end
            end
            S7: begin
                if (MHZ8_EN1) begin
                    state_d    = IDLE;
                    rw_d       = 1'b1;
                    doe_d      = 1'b0;
                    ack_d      = 1'b1;
                    berr_d     = berr_f;
                    busy_d     = 1'b0;
                    wait_cnt_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_m68k_bus_master.sv
// Directed bench for m68k_bus_master: word/byte reads and writes, wait states, bus error,
// timeout and mid-cycle reset, with expected values worked out by hand.
module tb_m68k_bus_master;

    logic        clk32, res, en1, en2;
    logic        req, we, uds, lds;
    logic [22:0] addr;
    logic [2:0]  fc;
    logic [15:0] wdata;
    logic        busy, ack, berr;
    logic [15:0] rdata;
    logic [22:0] A;
    logic [2:0]  FC;
    logic        AS_N, UDS_N, LDS_N, RW, DOE;
    logic [15:0] DOUT, DIN;
    logic        DTACK_N, BERR_N;
    logic [1:0]  phase;

    int total = 0;
    int bad   = 0;

    int          r_got_ack, r_ack_rel, r_as_low, r_uds_low, r_lds_low, r_rw_low;
    int          r_doe_cnt, r_dout_bad, r_strobe_bad, r_ack_after;
    logic        r_berr, r_rw_ack, r_as_ack, r_uds_ack, r_lds_ack, r_doe_ack;
    logic [15:0] r_rdata;
    logic [22:0] r_a;
    logic [2:0]  r_fc;

    m68k_bus_master #(.TIMEOUT(4), .TO_W(7)) dut (
        .clk32(clk32), .res(res), .MHZ8_EN1(en1), .MHZ8_EN2(en2),
        .req(req), .we(we), .addr(addr), .uds(uds), .lds(lds), .fc(fc), .wdata(wdata),
        .busy(busy), .ack(ack), .berr(berr), .rdata(rdata),
        .A(A), .FC(FC), .AS_N(AS_N), .UDS_N(UDS_N), .LDS_N(LDS_N), .RW(RW),
        .DOUT(DOUT), .DOE(DOE), .DIN(DIN), .DTACK_N(DTACK_N), .BERR_N(BERR_N)
    );

    initial clk32 = 1'b0;
    always #5 clk32 = ~clk32;

    // 8 MHz enables: EN1 and EN2 two clk32 apart, each once every four clk32.
    initial begin
        en1   = 1'b0;
        en2   = 1'b0;
        phase = 2'd0;
        forever begin
            @(negedge clk32);
            phase = phase + 2'd1;
            en1   = (phase == 2'd0);
            en2   = (phase == 2'd2);
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Issues one command and watches the bus until ack (or abort / budget expiry).
    // waits<0 keeps DTACK_N high forever; abort_at>=0 pulses res that many clk32 after AS_N falls.
    task automatic applyStimulus(input logic w, input logic [22:0] a, input logic u, input logic l,
                                 input logic [2:0] f, input logic [15:0] wd, input logic [15:0] din_v,
                                 input int waits, input logic berr_on, input logic inject,
                                 input int abort_at);
        int as_seen, as_i, rel, thr;
        as_seen = 0; as_i = 0; rel = 0;
        thr = (waits == 0) ? 0 : 4 * waits + 2;
        r_got_ack = 0; r_ack_rel = -1; r_as_low = 0; r_uds_low = 0; r_lds_low = 0;
        r_rw_low = 0; r_doe_cnt = 0; r_dout_bad = 0; r_strobe_bad = 0; r_ack_after = 0;
        @(negedge clk32);
        we = w; addr = a; uds = u; lds = l; fc = f; wdata = wd; DIN = din_v;
        DTACK_N = 1'b1; BERR_N = 1'b1; req = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk32);
            if (!as_seen && busy) req = 1'b0;
            if (!as_seen && !AS_N) begin
                as_seen = 1;
                as_i    = i;
            end
            if (as_seen) rel = i - as_i;
            if (!AS_N)  r_as_low++;
            if (!UDS_N) r_uds_low++;
            if (!LDS_N) r_lds_low++;
            if (!RW)    r_rw_low++;
            if (DOE) begin
                r_doe_cnt++;
                if (DOUT !== wd) r_dout_bad++;
            end
            if (AS_N && (!UDS_N || !LDS_N)) r_strobe_bad++;
            if (as_seen && waits >= 0 && rel >= thr) DTACK_N = 1'b0;
            if (as_seen && berr_on) BERR_N = 1'b0;
            if (inject && as_seen && rel == 2) begin
                req = 1'b1; addr = a ^ 23'h7FFFFF; fc = ~f; we = ~w;
            end
            if (inject && as_seen && rel == 4) req = 1'b0;
            if (ack) begin
                r_got_ack = 1;
                r_ack_rel = as_seen ? rel : -1;
                r_berr = berr; r_rdata = rdata; r_a = A; r_fc = FC;
                r_rw_ack = RW; r_as_ack = AS_N; r_uds_ack = UDS_N; r_lds_ack = LDS_N;
                r_doe_ack = DOE;
                @(negedge clk32);
                r_ack_after = ack;
                break;
            end
            if (abort_at >= 0 && as_seen && rel == abort_at) begin
                res = 1'b1;
                @(negedge clk32);
                res = 1'b0;
                break;
            end
        end
        DTACK_N = 1'b1;
        BERR_N  = 1'b1;
        req     = 1'b0;
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, ".AS_N"},  32'(AS_N),  32'd1);
        checkOutput({tag, ".UDS_N"}, 32'(UDS_N), 32'd1);
        checkOutput({tag, ".LDS_N"}, 32'(LDS_N), 32'd1);
        checkOutput({tag, ".RW"},    32'(RW),    32'd1);
        checkOutput({tag, ".A"},     32'(A),     32'd0);
        checkOutput({tag, ".FC"},    32'(FC),    32'd0);
        checkOutput({tag, ".DOUT"},  32'(DOUT),  32'd0);
        checkOutput({tag, ".DOE"},   32'(DOE),   32'd0);
        checkOutput({tag, ".busy"},  32'(busy),  32'd0);
        checkOutput({tag, ".ack"},   32'(ack),   32'd0);
        checkOutput({tag, ".berr"},  32'(berr),  32'd0);
        checkOutput({tag, ".rdata"}, 32'(rdata), 32'd0);
    endtask

    initial begin
        int quiet_bad;
        res = 1'b1; req = 1'b0; we = 1'b0; addr = '0; uds = 1'b0; lds = 1'b0;
        fc = '0; wdata = '0; DIN = '0; DTACK_N = 1'b1; BERR_N = 1'b1;
        repeat (4) @(negedge clk32);
        checkReset("reset");
        res = 1'b0;
        repeat (3) @(negedge clk32);

        $display("[TB] word read 0xE00000, zero waits");
        applyStimulus(1'b0, 23'h700000, 1'b1, 1'b1, 3'd5, 16'h0000, 16'h601E, 0, 1'b0, 1'b0, -1);
        checkOutput("rd.got_ack",   32'(r_got_ack), 32'd1);
        checkOutput("rd.ack_rel",   32'(r_ack_rel), 32'd12);
        checkOutput("rd.rdata",     32'(r_rdata),   32'h601E);
        checkOutput("rd.berr",      32'(r_berr),    32'd0);
        checkOutput("rd.as_low",    32'(r_as_low),  32'd10);
        checkOutput("rd.uds_low",   32'(r_uds_low), 32'd10);
        checkOutput("rd.lds_low",   32'(r_lds_low), 32'd10);
        checkOutput("rd.rw_low",    32'(r_rw_low),  32'd0);
        checkOutput("rd.A",         32'(r_a),       32'h700000);
        checkOutput("rd.FC",        32'(r_fc),      32'd5);
        checkOutput("rd.ack_width", 32'(r_ack_after), 32'd0);
        checkOutput("rd.strobes",   32'(r_strobe_bad), 32'd0);

        $display("[TB] byte write 0xFF8240 low byte");
        applyStimulus(1'b1, 23'h7FC120, 1'b0, 1'b1, 3'd5, 16'h0777, 16'hDEAD, 0, 1'b0, 1'b0, -1);
        checkOutput("wr.ack_rel",   32'(r_ack_rel),  32'd12);
        checkOutput("wr.rw_low",    32'(r_rw_low),   32'd12);
        checkOutput("wr.lds_low",   32'(r_lds_low),  32'd6);
        checkOutput("wr.uds_low",   32'(r_uds_low),  32'd0);
        checkOutput("wr.doe_cnt",   32'(r_doe_cnt),  32'd10);
        checkOutput("wr.dout",      32'(r_dout_bad), 32'd0);
        checkOutput("wr.doe_ack",   32'(r_doe_ack),  32'd0);
        checkOutput("wr.rw_ack",    32'(r_rw_ack),   32'd1);
        checkOutput("wr.rdata",     32'(r_rdata),    32'h601E);
        checkOutput("wr.A",         32'(r_a),        32'h7FC120);

        $display("[TB] read with three wait states");
        applyStimulus(1'b0, 23'h000100, 1'b0, 1'b0, 3'd6, 16'h0000, 16'h1234, 3, 1'b0, 1'b0, -1);
        checkOutput("wt.ack_rel",   32'(r_ack_rel), 32'd24);
        checkOutput("wt.as_low",    32'(r_as_low),  32'd22);
        checkOutput("wt.uds_low",   32'(r_uds_low), 32'd22);
        checkOutput("wt.rdata",     32'(r_rdata),   32'h1234);
        checkOutput("wt.berr",      32'(r_berr),    32'd0);

        $display("[TB] bus error on read");
        applyStimulus(1'b0, 23'h3FFFFF, 1'b1, 1'b1, 3'd1, 16'h0000, 16'hBEEF, -1, 1'b1, 1'b0, -1);
        checkOutput("be.ack_rel",   32'(r_ack_rel), 32'd12);
        checkOutput("be.berr",      32'(r_berr),    32'd1);
        checkOutput("be.rdata",     32'(r_rdata),   32'h1234);
        checkOutput("be.as_low",    32'(r_as_low),  32'd10);

        $display("[TB] timeout with DTACK_N and BERR_N high");
        applyStimulus(1'b0, 23'h000002, 1'b1, 1'b0, 3'd2, 16'h0000, 16'h5555, -1, 1'b0, 1'b0, -1);
        checkOutput("to.got_ack",   32'(r_got_ack), 32'd1);
        checkOutput("to.ack_rel",   32'(r_ack_rel), 32'd28);
        checkOutput("to.berr",      32'(r_berr),    32'd1);
        checkOutput("to.as_low",    32'(r_as_low),  32'd26);
        checkOutput("to.as_ack",    32'(r_as_ack),  32'd1);
        checkOutput("to.uds_ack",   32'(r_uds_ack), 32'd1);
        checkOutput("to.lds_ack",   32'(r_lds_ack), 32'd1);
        checkOutput("to.rdata",     32'(r_rdata),   32'h1234);

        $display("[TB] reset pulsed during a wait state");
        applyStimulus(1'b1, 23'h0ABCDE, 1'b1, 1'b1, 3'd5, 16'hA5A5, 16'h0000, -1, 1'b0, 1'b0, 6);
        checkOutput("ab.got_ack",   32'(r_got_ack), 32'd0);
        checkReset("abort");
        quiet_bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk32);
            if (ack || busy || !AS_N) quiet_bad++;
        end
        checkOutput("ab.quiet",     32'(quiet_bad), 32'd0);

        $display("[TB] second request while busy");
        applyStimulus(1'b0, 23'h012345, 1'b1, 1'b1, 3'd5, 16'h0000, 16'h4321, 0, 1'b0, 1'b1, -1);
        checkOutput("ig.ack_rel",   32'(r_ack_rel), 32'd12);
        checkOutput("ig.A",         32'(r_a),       32'h012345);
        checkOutput("ig.FC",        32'(r_fc),      32'd5);
        checkOutput("ig.rdata",     32'(r_rdata),   32'h4321);
        checkOutput("ig.rw_low",    32'(r_rw_low),  32'd0);
        quiet_bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk32);
            if (busy || !AS_N) quiet_bad++;
        end
        checkOutput("ig.quiet",     32'(quiet_bad), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
